// File: rtl/seq_player_if.sv
// Handshake bundle for seq_player: game control, generator link, keys and display.
// master = game environment, slave = seq_player.
interface seq_player_if;
    logic       start;
    logic [1:0] rand_in;
    logic [3:0] key;
    logic       rand_req;
    logic [3:0] led;
    logic [3:0] level;
    logic       await_input;
    logic       win;
    logic       fail;

    modport master (
        output start, rand_in, key,
        input  rand_req, led, level, await_input, win, fail
    );

    modport slave (
        input  start, rand_in, key,
        output rand_req, led, level, await_input, win, fail
    );
endinterface

// File: rtl/seq_player.sv
// Memory-game sequencer: requests random symbols, plays them on the LEDs, checks the player's keys.
// Optional input timeout is enabled by defining SEQ_PLAYER_TIMEOUT_EN.
module seq_player #(
    parameter int SEQ_MAX        = 8,
    parameter int HOLD_CYCLES    = 4,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    seq_player_if.slave bus
);

    localparam int IW   = (SEQ_MAX > 2) ? $clog2(SEQ_MAX) : 1;
    localparam int LW   = $clog2(SEQ_MAX + 1);
    localparam int TMAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int TW   = (TMAX > 2) ? $clog2(TMAX) : 1;

    localparam logic [LW-1:0] LVL_MAX   = LW'(SEQ_MAX);
    localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_REQ      = 4'd1,
        S_WAIT     = 4'd2,
        S_STORE    = 4'd3,
        S_PLAY_ON  = 4'd4,
        S_PLAY_GAP = 4'd5,
        S_INPUT    = 4'd6,
        S_PASS     = 4'd7,
        S_FAIL     = 4'd8
    } state_t;

    function automatic logic [3:0] sym_onehot(input logic [1:0] sym);
        logic [3:0] oh;
        case (sym)
            2'd0:    oh = 4'b0001;
            2'd1:    oh = 4'b0010;
            2'd2:    oh = 4'b0100;
            2'd3:    oh = 4'b1000;
            default: oh = 4'b0000;
        endcase
        return oh;
    endfunction

    state_t          state_q, state_d;
    logic [LW-1:0]   level_q, level_d;
    logic [IW-1:0]   index_q, index_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [3:0]      key_prev_q, key_prev_d;
    logic            rand_req_q, rand_req_d;
    logic [3:0]      led_q, led_d;
    logic            await_q, await_d;
    logic            win_q, win_d;
    logic            fail_q, fail_d;

    logic [1:0]      mem_q [0:(2**IW)-1];
    logic            mem_we_s;
    logic [IW-1:0]   wr_idx_s;
    logic [3:0]      exp_key_s;
    logic            press_s;
    logic [LW-1:0]   index_nxt_s;
    logic            last_s;
    logic [1:0]      led_sym_s;

`ifdef SEQ_PLAYER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] IDLE_LAST = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0]   idle_q, idle_d;
`else
    logic [31:0]     unused_timeout_s;
    assign unused_timeout_s = 32'(TIMEOUT_CYCLES);
`endif

    // A press is a fresh key-down: held keys (including ones held across INPUT entry) never re-trigger.
    assign key_prev_d  = bus.key;
    assign exp_key_s   = sym_onehot(mem_q[index_q]);
    assign press_s     = (bus.key != 4'b0000) && (key_prev_q == 4'b0000);
    assign index_nxt_s = LW'(index_q) + LW'(1'b1);
    assign last_s      = (index_nxt_s == level_q);
    assign wr_idx_s    = IW'(level_q - LW'(1'b1));

    // Next-state, level, index and playback timer.
    always_comb begin
        state_d  = state_q;
        level_d  = level_q;
        index_d  = index_q;
        timer_d  = timer_q;
        mem_we_s = 1'b0;
        case (state_q)
            S_IDLE, S_PASS, S_FAIL: begin
                if (bus.start) begin
                    state_d = S_REQ;
                    level_d = LW'(1'b1);
                end else begin
                    state_d = state_q;
                end
            end
            S_REQ:  state_d = S_WAIT;
            S_WAIT: state_d = S_STORE;
            S_STORE: begin
                mem_we_s = 1'b1;
                index_d  = {IW{1'b0}};
                timer_d  = {TW{1'b0}};
                state_d  = S_PLAY_ON;
            end
            S_PLAY_ON: begin
                if (timer_q == HOLD_LAST) begin
                    timer_d = {TW{1'b0}};
                    state_d = S_PLAY_GAP;
                end else begin
                    timer_d = timer_q + TW'(1'b1);
                end
            end
            S_PLAY_GAP: begin
                if (timer_q == GAP_LAST) begin
                    timer_d = {TW{1'b0}};
                    if (last_s) begin
                        index_d = {IW{1'b0}};
                        state_d = S_INPUT;
                    end else begin
                        index_d = index_q + IW'(1'b1);
                        state_d = S_PLAY_ON;
                    end
                end else begin
                    timer_d = timer_q + TW'(1'b1);
                end
            end
            S_INPUT: begin
                if (press_s) begin
                    if (bus.key == exp_key_s) begin
                        if (!last_s) begin
                            index_d = index_q + IW'(1'b1);
                        end else if (level_q == LVL_MAX) begin
                            state_d = S_PASS;
                        end else begin
                            level_d = level_q + LW'(1'b1);
                            index_d = {IW{1'b0}};
                            state_d = S_REQ;
                        end
                    end else begin
                        state_d = S_FAIL;
                    end
                end else begin
`ifdef SEQ_PLAYER_TIMEOUT_EN
                    if (idle_q == IDLE_LAST) begin
                        state_d = S_FAIL;
                    end else begin
                        state_d = S_INPUT;
                    end
`else
                    state_d = S_INPUT;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef SEQ_PLAYER_TIMEOUT_EN
    // Idle counter restarts on INPUT entry and on every fresh press.
    always_comb begin
        if ((state_q == S_INPUT) && !press_s) begin
            idle_d = idle_q + CW'(1'b1);
        end else begin
            idle_d = {CW{1'b0}};
        end
    end
`endif

    // Outputs are decoded from the next state so the registered outputs line up with the state register.
    always_comb begin
        if (mem_we_s && (index_d == wr_idx_s)) begin
            led_sym_s = bus.rand_in;
        end else begin
            led_sym_s = mem_q[index_d];
        end
        if (state_d == S_PLAY_ON) begin
            led_d = sym_onehot(led_sym_s);
        end else begin
            led_d = 4'b0000;
        end
        rand_req_d = (state_d == S_REQ);
        await_d    = (state_d == S_INPUT);
        win_d      = (state_d == S_PASS);
        fail_d     = (state_d == S_FAIL);
    end

    // Control and output registers; reset returns to IDLE from anywhere.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            level_q    <= {LW{1'b0}};
            index_q    <= {IW{1'b0}};
            timer_q    <= {TW{1'b0}};
            key_prev_q <= 4'b0000;
            rand_req_q <= 1'b0;
            led_q      <= 4'b0000;
            await_q    <= 1'b0;
            win_q      <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            index_q    <= index_d;
            timer_q    <= timer_d;
            key_prev_q <= key_prev_d;
            rand_req_q <= rand_req_d;
            led_q      <= led_d;
            await_q    <= await_d;
            win_q      <= win_d;
            fail_q     <= fail_d;
        end
    end

`ifdef SEQ_PLAYER_TIMEOUT_EN
    // Input timeout counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idle_q <= {CW{1'b0}};
        end else begin
            idle_q <= idle_d;
        end
    end
`endif

    // Symbol store; contents survive reset and new games because each slot is rewritten before it is played.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[wr_idx_s] <= bus.rand_in;
        end
    end

    assign bus.rand_req    = rand_req_q;
    assign bus.led         = led_q;
    assign bus.level       = 4'(level_q);
    assign bus.await_input = await_q;
    assign bus.win         = win_q;
    assign bus.fail        = fail_q;

endmodule

// File: tb/tb_seq_player.sv
// Directed bench for seq_player (SEQ_MAX=4, HOLD=3, GAP=2, TIMEOUT=10); honours SEQ_PLAYER_TIMEOUT_EN.
module tb_seq_player;

    logic clk;
    logic reset_n;
    int   total;
    int   bad;
    int   req_cnt;
    int   req_base;
    logic [1:0] sym_q [$];
    logic [3:0] game_keys [4];

    seq_player_if bus ();

    seq_player #(
        .SEQ_MAX        (4),
        .HOLD_CYCLES    (3),
        .GAP_CYCLES     (2),
        .TIMEOUT_CYCLES (10)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_await(input string tag, input int budget);
        for (int i = 0; i < budget && bus.await_input !== 1'b1; i++) @(negedge clk);
        check_eq(tag, 32'(bus.await_input), 32'd1);
    endtask

    task automatic wait_led(input string tag, input int budget);
        for (int i = 0; i < budget && bus.led === 4'b0000; i++) @(negedge clk);
        check_eq(tag, 32'(bus.led != 4'b0000), 32'd1);
    endtask

    task automatic press(input logic [3:0] k);
        bus.key = k;
        @(negedge clk);
        bus.key = 4'b0000;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Random generator model: answers each rand_req two cycles later with the next queued symbol.
    initial begin
        req_cnt     = 0;
        bus.rand_in = 2'd0;
        forever begin
            @(negedge clk);
            if (bus.rand_req === 1'b1) begin
                req_cnt++;
                bus.rand_in = 2'b11 ^ ((sym_q.size() > 0) ? sym_q[0] : 2'd0);
                @(negedge clk);
                @(negedge clk);
                bus.rand_in = (sym_q.size() > 0) ? sym_q.pop_front() : 2'd0;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        game_keys[0] = 4'b0010;
        game_keys[1] = 4'b1000;
        game_keys[2] = 4'b0001;
        game_keys[3] = 4'b0100;
        reset_n   = 1'b0;
        bus.start = 1'b0;
        bus.key   = 4'b0000;
        repeat (3) @(negedge clk);
        check_eq("rst_rand_req", 32'(bus.rand_req), 32'd0);
        check_eq("rst_led", 32'(bus.led), 32'd0);
        check_eq("rst_level", 32'(bus.level), 32'd0);
        check_eq("rst_await", 32'(bus.await_input), 32'd0);
        check_eq("rst_win", 32'(bus.win), 32'd0);
        check_eq("rst_fail", 32'(bus.fail), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("idle_level", 32'(bus.level), 32'd0);

        // First round with symbol 2: 3 cycles lit, 2 dark, then INPUT.
        sym_q.push_back(2'd2);
        pulse_start();
        check_eq("s1_rand_req", 32'(bus.rand_req), 32'd1);
        check_eq("s1_level", 32'(bus.level), 32'd1);
        wait_led("s1_led_on", 10);
        for (int i = 0; i < 3; i++) begin
            check_eq("s1_play_on", 32'(bus.led), 32'h4);
            @(negedge clk);
        end
        for (int i = 0; i < 2; i++) begin
            check_eq("s1_gap_led", 32'(bus.led), 32'd0);
            check_eq("s1_gap_await", 32'(bus.await_input), 32'd0);
            @(negedge clk);
        end
        check_eq("s1_await", 32'(bus.await_input), 32'd1);
        check_eq("s1_level_in", 32'(bus.level), 32'd1);
        bus.key = 4'b0001;
        @(negedge clk);
        bus.key = 4'b0000;
        check_eq("s1_wrong_fail", 32'(bus.fail), 32'd1);
        check_eq("s1_wrong_await", 32'(bus.await_input), 32'd0);
        check_eq("s1_wrong_level", 32'(bus.level), 32'd1);

        // Full game 1,3,0,2 started from FAIL.
        sym_q.delete();
        sym_q.push_back(2'd1);
        sym_q.push_back(2'd3);
        sym_q.push_back(2'd0);
        sym_q.push_back(2'd2);
        req_base = req_cnt;
        pulse_start();
        for (int r = 1; r <= 4; r++) begin
            wait_await("s2_await", 40);
            check_eq("s2_level", 32'(bus.level), 32'(r));
            for (int i = 0; i < r; i++) press(game_keys[i]);
        end
        check_eq("s2_win", 32'(bus.win), 32'd1);
        check_eq("s2_level_fin", 32'(bus.level), 32'd4);
        check_eq("s2_req_pulses", 32'(req_cnt - req_base), 32'd4);
        repeat (5) @(negedge clk);
        check_eq("s2_win_hold", 32'(bus.win), 32'd1);
        check_eq("s2_level_hold", 32'(bus.level), 32'd4);

        // Sequence 1,3: wrong key 1000 at index 0 of level 2.
        sym_q.delete();
        sym_q.push_back(2'd1);
        sym_q.push_back(2'd3);
        pulse_start();
        wait_await("s3_await1", 40);
        press(4'b0010);
        wait_await("s3_await2", 40);
        check_eq("s3_level2", 32'(bus.level), 32'd2);
        bus.key = 4'b1000;
        @(negedge clk);
        bus.key = 4'b0000;
        check_eq("s3_fail", 32'(bus.fail), 32'd1);
        check_eq("s3_level_kept", 32'(bus.level), 32'd2);
        check_eq("s3_await_off", 32'(bus.await_input), 32'd0);

        // Held keys: wrong key held through playback and INPUT entry is ignored; held correct key counts once.
        sym_q.delete();
        sym_q.push_back(2'd1);
        sym_q.push_back(2'd1);
        sym_q.push_back(2'd0);
        pulse_start();
        wait_led("s4_led_on", 10);
        bus.key = 4'b1000;
        wait_await("s4_await1", 40);
        repeat (3) @(negedge clk);
        check_eq("s4_held_fail", 32'(bus.fail), 32'd0);
        check_eq("s4_held_await", 32'(bus.await_input), 32'd1);
        check_eq("s4_held_level", 32'(bus.level), 32'd1);
        bus.key = 4'b0000;
        @(negedge clk);
        press(4'b0010);
        wait_await("s4_await2", 40);
        check_eq("s4_level2", 32'(bus.level), 32'd2);
        bus.key = 4'b0010;
        repeat (5) @(negedge clk);
        check_eq("s4_hold_await", 32'(bus.await_input), 32'd1);
        check_eq("s4_hold_level", 32'(bus.level), 32'd2);
        bus.key = 4'b0000;
        @(negedge clk);
        press(4'b0010);
        check_eq("s4_round_done", 32'(bus.level), 32'd3);
        check_eq("s4_await_off", 32'(bus.await_input), 32'd0);

        // Asynchronous reset during playback of level 3.
        wait_led("s5_led_on", 30);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("s5_rst_led", 32'(bus.led), 32'd0);
        check_eq("s5_rst_level", 32'(bus.level), 32'd0);
        check_eq("s5_rst_await", 32'(bus.await_input), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        sym_q.delete();
        sym_q.push_back(2'd3);
        @(negedge clk);
        pulse_start();
        check_eq("s5_restart_level", 32'(bus.level), 32'd1);
        check_eq("s5_restart_req", 32'(bus.rand_req), 32'd1);
        wait_led("s5_led_on2", 10);
        check_eq("s5_led_sym", 32'(bus.led), 32'h8);
        wait_await("s5_await", 20);
        check_eq("s5_level_in", 32'(bus.level), 32'd1);

        // No key in INPUT.
`ifdef SEQ_PLAYER_TIMEOUT_EN
        repeat (9) @(negedge clk);
        check_eq("s6_before_to_await", 32'(bus.await_input), 32'd1);
        check_eq("s6_before_to_fail", 32'(bus.fail), 32'd0);
        @(negedge clk);
        check_eq("s6_timeout_fail", 32'(bus.fail), 32'd1);
        check_eq("s6_timeout_await", 32'(bus.await_input), 32'd0);
`else
        repeat (60) @(negedge clk);
        check_eq("s6_no_to_await", 32'(bus.await_input), 32'd1);
        check_eq("s6_no_to_fail", 32'(bus.fail), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
